// File: rtl/key_addition_pkg.sv
// rtl/key_addition_pkg.sv - shared constants, FSM states and voter for the redundant key-addition stage
package key_addition_pkg;

    localparam int MODE_NONE = 0;
    localparam int MODE_DUP  = 1;
    localparam int MODE_TMR  = 2;

    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/key_addition_lane.sv
// rtl/key_addition_lane.sv - one redundant lane: private key register plus registered state XOR key
module key_addition_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_key_load,
    input  logic [WIDTH-1:0] i_key,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_key;
    logic [WIDTH-1:0] r_data;

    // A word accepted together with a key load still sees the old key.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_key  <= '0;
            r_data <= '0;
        end else begin
            if (i_en)
                r_data <= i_state ^ r_key;
            if (i_key_load)
                r_key <= i_key;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/key_addition_redundant.sv
// rtl/key_addition_redundant.sv - registered key addition with none/duplicate/TMR lanes and a stream handshake
module key_addition_redundant
    import key_addition_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int REDUNDANCY   = 0,
    parameter bit FAULT_STICKY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_key_load,
    input  logic [WIDTH-1:0] io_key,
    output logic             io_key_valid,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_state,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out,
    output logic             io_fault,
    output logic             io_corrected,
    input  logic             io_clear_fault
);

    localparam int LANES = REDUNDANCY + 1;

    state_t           r_state;
    state_t           w_next;
    logic             r_out_valid;
    logic             r_key_valid;
    logic             r_fault;
    logic [WIDTH-1:0] w_lane [3];
    logic [WIDTH-1:0] w_voted;
    logic             w_accept;
    logic             w_mismatch;
    logic             w_dup_err;

    for (genvar g = 0; g < 3; g++) begin : gen_lane
        if (g < LANES) begin : g_on
            (* keep = "true", dont_touch = "true" *)
            key_addition_lane #(.WIDTH(WIDTH)) u_lane (
                .clock      (clock),
                .reset      (reset),
                .i_key_load (io_key_load),
                .i_key      (io_key),
                .i_en       (w_accept),
                .i_state    (io_state),
                .o_data     (w_lane[g])
            );
        end else begin : g_off
            assign w_lane[g] = '0;
        end
    end

    always_comb begin
        w_mismatch = 1'b0;
        for (int i = 0; i < WIDTH; i++)
            w_voted[i] = majority3(w_lane[0][i], w_lane[1][i], w_lane[2][i]);
        if (REDUNDANCY == MODE_DUP)
            w_mismatch = r_out_valid && (w_lane[0] != w_lane[1]);
        else if (REDUNDANCY == MODE_TMR)
            w_mismatch = r_out_valid && ((w_lane[0] != w_lane[1]) || (w_lane[0] != w_lane[2]));
    end

    // A duplicate-mode mismatch suppresses the word in the same cycle it is seen.
    assign w_dup_err    = (REDUNDANCY == MODE_DUP) && w_mismatch;
    assign io_out_valid = r_out_valid && !w_dup_err;
    assign io_in_ready  = (r_state == RUN) && !w_dup_err && (!r_out_valid || io_out_ready);
    assign w_accept     = io_in_valid && io_in_ready;
    assign io_key_valid = r_key_valid;
    assign io_fault     = FAULT_STICKY ? (r_fault || w_mismatch) : w_mismatch;
    assign io_corrected = (REDUNDANCY == MODE_TMR) && w_mismatch;

    always_comb begin
        io_out = w_lane[0];
        if (REDUNDANCY == MODE_DUP && w_dup_err)
            io_out = '0;
        else if (REDUNDANCY == MODE_TMR)
            io_out = w_voted;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            NOKEY:   if (io_key_load) w_next = RUN;
            RUN:     if (w_dup_err && !io_clear_fault) w_next = FAULT;
            FAULT:   if (io_clear_fault) w_next = RUN;
            default: w_next = NOKEY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= NOKEY;
            r_out_valid <= 1'b0;
            r_key_valid <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= w_accept || (r_out_valid && !io_out_ready && !w_dup_err);
            r_key_valid <= r_key_valid || io_key_load;
            if (io_clear_fault)
                r_fault <= 1'b0;
            else if (w_mismatch)
                r_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_key_addition_redundant.sv
// tb/tb_key_addition_redundant.sv - scoreboard bench over single, duplicate and TMR instances
module tb_key_addition_redundant;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic       key_load0, in_valid0, in_ready0, out_valid0, out_ready0, key_valid0, fault0, corr0, clear0;
    logic [7:0] key0, state0, out0;
    logic         key_load1, in_valid1, in_ready1, out_valid1, out_ready1, key_valid1, fault1, corr1, clear1;
    logic [127:0] key1, state1, out1;
    logic       key_load2, in_valid2, in_ready2, out_valid2, out_ready2, key_valid2, fault2, corr2, clear2;
    logic [7:0] key2, state2, out2;

    key_addition_redundant #(.WIDTH(8), .REDUNDANCY(0)) dut0 (
        .clock(clock), .reset(reset), .io_key_load(key_load0), .io_key(key0), .io_key_valid(key_valid0),
        .io_in_valid(in_valid0), .io_in_ready(in_ready0), .io_state(state0), .io_out_valid(out_valid0),
        .io_out_ready(out_ready0), .io_out(out0), .io_fault(fault0), .io_corrected(corr0), .io_clear_fault(clear0));

    key_addition_redundant #(.WIDTH(128), .REDUNDANCY(1)) dut1 (
        .clock(clock), .reset(reset), .io_key_load(key_load1), .io_key(key1), .io_key_valid(key_valid1),
        .io_in_valid(in_valid1), .io_in_ready(in_ready1), .io_state(state1), .io_out_valid(out_valid1),
        .io_out_ready(out_ready1), .io_out(out1), .io_fault(fault1), .io_corrected(corr1), .io_clear_fault(clear1));

    key_addition_redundant #(.WIDTH(8), .REDUNDANCY(2)) dut2 (
        .clock(clock), .reset(reset), .io_key_load(key_load2), .io_key(key2), .io_key_valid(key_valid2),
        .io_in_valid(in_valid2), .io_in_ready(in_ready2), .io_state(state2), .io_out_valid(out_valid2),
        .io_out_ready(out_ready2), .io_out(out2), .io_fault(fault2), .io_corrected(corr2), .io_clear_fault(clear2));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each instance holds a key; an accepted word yields word ^ key-at-accept.
    logic [7:0]   q0[$];
    logic [127:0] q1[$];
    logic [7:0]   q2[$];
    logic [7:0]   mkey0, mkey2;
    logic [127:0] mkey1;
    logic         prev_hold1;

    always @(negedge clock) begin
        if (!reset) begin
            q0.delete(); q1.delete(); q2.delete();
            mkey0 = '0; mkey1 = '0; mkey2 = '0;
            prev_hold1 = 1'b0;
        end else begin
            if (in_valid0 && in_ready0) q0.push_back(state0 ^ mkey0);
            if (key_load0) mkey0 = key0;
            if (in_valid1 && in_ready1) q1.push_back(state1 ^ mkey1);
            if (key_load1) mkey1 = key1;
            if (in_valid2 && in_ready2) q2.push_back(state2 ^ mkey2);
            if (key_load2) mkey2 = key2;

            if (out_valid0 && out_ready0) begin
                if (q0.size() == 0) check("u0 unexpected output", 1'b1, 1'b0);
                else check("u0 out", out0, q0.pop_front());
            end
            // A held duplicate-mode word that vanishes untransferred must be a detected fault.
            if (prev_hold1 && !out_valid1) begin
                check("u1 discard has fault", fault1, 1'b1);
                if (q1.size() != 0) void'(q1.pop_front());
            end
            prev_hold1 = out_valid1 && !out_ready1;
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) check("u1 unexpected output", 1'b1, 1'b0);
                else check("u1 out", out1, q1.pop_front());
            end
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) check("u2 unexpected output", 1'b1, 1'b0);
                else check("u2 out", out2, q2.pop_front());
            end
        end
    end

    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] w1, fval1;
    int cnt;

    initial begin
        {key_load0, in_valid0, out_ready0, clear0, key0, state0} = '0;
        {key_load1, in_valid1, out_ready1, clear1, key1, state1} = '0;
        {key_load2, in_valid2, out_ready2, clear2, key2, state2} = '0;
        w1 = '0; fval1 = '0; cnt = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst out_valid0", out_valid0, 1'b0);
        check("rst out0", out0, 8'h00);
        check("rst key_valid0", key_valid0, 1'b0);
        check("rst in_ready0", in_ready0, 1'b0);
        check("rst out_valid1", out_valid1, 1'b0);
        check("rst fault1", fault1, 1'b0);
        check("rst out2", out2, 8'h00);
        check("rst corrected2", corr2, 1'b0);
        check("rst fault2", fault2, 1'b0);
        @(negedge clock) reset = 1'b1;

        // No key yet: the word must be refused.
        @(posedge clock); #1 in_valid0 = 1'b1; state0 = 8'h3C; out_ready0 = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("nokey in_ready0", in_ready0, 1'b0);
            check("nokey out_valid0", out_valid0, 1'b0);
        end
        @(posedge clock); #1 key_load0 = 1'b1; key0 = 8'hA5;
        @(posedge clock); #1 key_load0 = 1'b0;
        check("key_valid0 after load", key_valid0, 1'b1);
        @(negedge clock) check("run in_ready0", in_ready0, 1'b1);
        @(posedge clock); #1 in_valid0 = 1'b0;
        @(negedge clock);
        check("latency out_valid0", out_valid0, 1'b1);
        check("first out0", out0, 8'h99);

        // Key load in the same cycle as an accept.
        @(posedge clock); #1 in_valid0 = 1'b1; state0 = 8'h0F; key_load0 = 1'b1; key0 = 8'hFF;
        @(posedge clock); #1 key_load0 = 1'b0;
        @(negedge clock) check("old key out0", out0, 8'hAA);
        @(posedge clock); #1 in_valid0 = 1'b0;
        @(negedge clock) check("new key out0", out0, 8'hF0);

        // Backpressure hold, then transfer with a same-cycle accept.
        @(posedge clock); #1 in_valid0 = 1'b1; state0 = 8'h11; out_ready0 = 1'b0;
        @(posedge clock); #1 state0 = 8'h22;
        repeat (3) begin
            @(negedge clock);
            check("hold out0", out0, 8'hEE);
            check("hold out_valid0", out_valid0, 1'b1);
            check("hold in_ready0", in_ready0, 1'b0);
        end
        @(posedge clock); #1 out_ready0 = 1'b1;
        @(negedge clock) check("release in_ready0", in_ready0, 1'b1);
        @(posedge clock); #1 in_valid0 = 1'b0;
        @(negedge clock) check("next word out0", out0, 8'hDD);

        // Randomized traffic on the single-lane instance.
        for (int i = 0; i < 80; i++) begin
            @(posedge clock); #1;
            in_valid0  = 1'($urandom_range(0, 1));
            state0     = 8'($urandom);
            out_ready0 = ($urandom_range(0, 3) != 0);
            key_load0  = ($urandom_range(0, 7) == 0);
            key0       = 8'($urandom);
        end
        @(posedge clock); #1 in_valid0 = 1'b0; key_load0 = 1'b0; out_ready0 = 1'b1;
        repeat (3) @(posedge clock);
        #1 check("u0 drained", 32'(q0.size()), 32'd0);
        check("u0 fault tied", fault0, 1'b0);

        // Duplicate mode, 128-bit, back-to-back stream.
        @(posedge clock); #1 key_load1 = 1'b1; key1 = K128; out_ready1 = 1'b1;
        @(posedge clock); #1 key_load1 = 1'b0;
        cnt = 0;
        for (int i = 0; i <= 16; i++) begin
            in_valid1 = (i < 16);
            state1    = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clock);
            if (out_valid1) cnt++;
            check("dup stream fault1", fault1, 1'b0);
            if (i < 16) check("dup stream in_ready1", in_ready1, 1'b1);
            @(posedge clock); #1;
        end
        in_valid1 = 1'b0;
        check("dup stream count", 32'(cnt), 32'd16);

        // Duplicate mode fault: flip lane1 bit 3 on a held word.
        w1 = {$urandom, $urandom, $urandom, $urandom};
        in_valid1 = 1'b1; state1 = w1; out_ready1 = 1'b0;
        @(posedge clock); #1 in_valid1 = 1'b0;
        @(negedge clock) check("dup held valid", out_valid1, 1'b1);
        fval1 = w1 ^ K128 ^ 128'h8;
        @(posedge clock); #1 force dut1.gen_lane[1].g_on.u_lane.r_data = fval1;
        #1;
        check("dup err out_valid1", out_valid1, 1'b0);
        check("dup err out1", out1, 128'h0);
        check("dup err fault1", fault1, 1'b1);
        check("dup err in_ready1", in_ready1, 1'b0);
        @(posedge clock); #1 release dut1.gen_lane[1].g_on.u_lane.r_data;
        check("fault state in_ready1", in_ready1, 1'b0);
        check("fault state fault1", fault1, 1'b1);
        @(posedge clock); #1 clear1 = 1'b1;
        @(posedge clock); #1 clear1 = 1'b0;
        check("cleared fault1", fault1, 1'b0);
        check("cleared in_ready1", in_ready1, 1'b1);
        out_ready1 = 1'b1; in_valid1 = 1'b1; state1 = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clock); #1 in_valid1 = 1'b0;
        @(negedge clock);
        check("post clear out_valid1", out_valid1, 1'b1);
        check("post clear fault1", fault1, 1'b0);
        @(posedge clock); #1;

        // TMR: flip lane2 bit 0 on a held word; the vote hides it.
        key_load2 = 1'b1; key2 = 8'hA5; out_ready2 = 1'b0;
        @(posedge clock); #1 key_load2 = 1'b0; in_valid2 = 1'b1; state2 = 8'h3C;
        @(posedge clock); #1 in_valid2 = 1'b0;
        @(negedge clock);
        @(posedge clock); #1 force dut2.gen_lane[2].g_on.u_lane.r_data = 8'h98;
        #1;
        check("tmr out2", out2, 8'h99);
        check("tmr corrected2", corr2, 1'b1);
        check("tmr fault2", fault2, 1'b1);
        check("tmr out_valid2", out_valid2, 1'b1);
        release dut2.gen_lane[2].g_on.u_lane.r_data;
        cnt = 0;
        for (int i = 0; i <= 8; i++) begin
            in_valid2 = (i < 8); state2 = 8'($urandom); out_ready2 = 1'b1;
            @(negedge clock);
            if (out_valid2) cnt++;
            check("tmr stream corrected2", corr2, (i == 0));
            @(posedge clock); #1;
        end
        in_valid2 = 1'b0;
        check("tmr stream count", 32'(cnt), 32'd9);
        check("tmr sticky fault2", fault2, 1'b1);

        // Asynchronous reset while an output is held.
        in_valid0 = 1'b1; state0 = 8'($urandom); out_ready0 = 1'b0;
        @(posedge clock); #1 in_valid0 = 1'b0;
        @(negedge clock) check("pre-reset held", out_valid0, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async rst out_valid0", out_valid0, 1'b0);
        check("async rst key_valid0", key_valid0, 1'b0);
        check("async rst out0", out0, 8'h00);
        check("async rst key_valid2", key_valid2, 1'b0);
        check("async rst fault2", fault2, 1'b0);
        repeat (2) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
